// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter with burst cap in front of one single-port synchronous SRAM.
// The SRAM command is registered; read data returns to the issuing requester after a fixed latency.
module sram_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int BURST_MAX  = 4
) (
    input  logic          CLK_BASE,
    input  logic          RESET,
    input  logic          R0_REQ,
    input  logic          R0_WE,
    input  logic [AW-1:0] R0_ADDR,
    input  logic [DW-1:0] R0_WDATA,
    output logic          R0_GNT,
    output logic          R0_RVALID,
    output logic [DW-1:0] R0_RDATA,
    input  logic          R1_REQ,
    input  logic          R1_WE,
    input  logic [AW-1:0] R1_ADDR,
    input  logic [DW-1:0] R1_WDATA,
    output logic          R1_GNT,
    output logic          R1_RVALID,
    output logic [DW-1:0] R1_RDATA,
    output logic          SRAM_CE,
    output logic          SRAM_WE,
    output logic [AW-1:0] SRAM_ADDR,
    output logic [DW-1:0] SRAM_WDATA,
    input  logic [DW-1:0] SRAM_RDATA,
    output logic          BUSY
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            last_r;
    logic            gnt0_s;
    logic            gnt1_s;
    logic            gnt0_g_s;
    logic            gnt1_g_s;
    logic            issue_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            rd_issue_s;
    logic            busy_nxt_s;
    logic [RD_LATENCY:0] pv_r;
    logic [RD_LATENCY:0] pid_r;

    // Arbitration decision and next owner/burst count
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (R0_REQ && R1_REQ) begin
                    gnt0_s = last_r;
                    gnt1_s = ~last_r;
                end else begin
                    gnt0_s = R0_REQ;
                    gnt1_s = R1_REQ;
                end
            end
            OWN0: begin
                if (R0_REQ && !((cnt_r == CNT_MAX) && R1_REQ)) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = R1_REQ;
                end
            end
            OWN1: begin
                if (R1_REQ && !((cnt_r == CNT_MAX) && R0_REQ)) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = R0_REQ;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        // Same owner keeps counting (saturating); a new owner restarts at one
        if (gnt0_s) begin
            state_nxt_s = OWN0;
            cnt_nxt_s   = (state_r != OWN0) ? CNT_ONE : ((cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE);
        end else if (gnt1_s) begin
            state_nxt_s = OWN1;
            cnt_nxt_s   = (state_r != OWN1) ? CNT_ONE : ((cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE);
        end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
        end
    end

    // A grant seen while reset is held must not leak out
    assign gnt0_g_s    = gnt0_s & ~RESET;
    assign gnt1_g_s    = gnt1_s & ~RESET;
    assign R0_GNT      = gnt0_g_s;
    assign R1_GNT      = gnt1_g_s;
    assign issue_s     = gnt0_g_s | gnt1_g_s;
    assign sel_we_s    = gnt1_g_s ? R1_WE    : R0_WE;
    assign sel_addr_s  = gnt1_g_s ? R1_ADDR  : R0_ADDR;
    assign sel_wdata_s = gnt1_g_s ? R1_WDATA : R0_WDATA;
    assign rd_issue_s  = issue_s & ~sel_we_s;
    assign busy_nxt_s  = (state_nxt_s != IDLE) | rd_issue_s | (|pv_r[RD_LATENCY-1:0]);

    // Arbiter state, burst counter and last-granted index
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (issue_s) begin
                last_r <= gnt1_g_s;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Registered SRAM command; address and data hold when no access is issued
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            SRAM_CE    <= 1'b0;
            SRAM_WE    <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else begin
            SRAM_CE <= issue_s;
            if (issue_s) begin
                SRAM_WE    <= sel_we_s;
                SRAM_ADDR  <= sel_addr_s;
                SRAM_WDATA <= sel_wdata_s;
            end else begin
                SRAM_WE    <= SRAM_WE;
                SRAM_ADDR  <= SRAM_ADDR;
                SRAM_WDATA <= SRAM_WDATA;
            end
        end
    end

    // Read owner pipeline: stage 0 lines up with SRAM_CE, the last stage with valid SRAM_RDATA
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            pv_r  <= '0;
            pid_r <= '0;
            BUSY  <= 1'b0;
        end else begin
            pv_r  <= {pv_r[RD_LATENCY-1:0], rd_issue_s};
            pid_r <= {pid_r[RD_LATENCY-1:0], gnt1_g_s};
            BUSY  <= busy_nxt_s;
        end
    end

    // Read return to the issuing requester
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            R0_RVALID <= 1'b0;
            R1_RVALID <= 1'b0;
            R0_RDATA  <= '0;
            R1_RDATA  <= '0;
        end else begin
            R0_RVALID <= pv_r[RD_LATENCY] & ~pid_r[RD_LATENCY];
            R1_RVALID <= pv_r[RD_LATENCY] &  pid_r[RD_LATENCY];
            if (pv_r[RD_LATENCY] && !pid_r[RD_LATENCY]) begin
                R0_RDATA <= SRAM_RDATA;
            end else begin
                R0_RDATA <= R0_RDATA;
            end
            if (pv_r[RD_LATENCY] && pid_r[RD_LATENCY]) begin
                R1_RDATA <= SRAM_RDATA;
            end else begin
                R1_RDATA <= R1_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (read latency 1..3) share one stimulus stream and
// are compared each cycle against a transaction-level arbiter/memory model.
module tb_sram_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BMAX = 4;
    localparam int NL   = 3;
    localparam int NW   = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    logic req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic gnt0 [NL];
    logic gnt1 [NL];
    logic rv0 [NL];
    logic rv1 [NL];
    logic ce [NL];
    logic swe [NL];
    logic busy [NL];
    logic [AW-1:0] saddr [NL];
    logic [DW-1:0] swdata [NL];
    logic [DW-1:0] rd0 [NL];
    logic [DW-1:0] rd1 [NL];
    logic [DW-1:0] srdata [NL];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    for (genvar k = 0; k < NL; k++) begin : g_lat
        logic [DW-1:0] smem [0:NW-1];
        logic [DW-1:0] spipe [0:NL-1];

        sram_port_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(k + 1), .BURST_MAX(BMAX)) dut (
            .CLK_BASE(clk), .RESET(rst),
            .R0_REQ(req0), .R0_WE(we0), .R0_ADDR(addr0), .R0_WDATA(wdata0),
            .R0_GNT(gnt0[k]), .R0_RVALID(rv0[k]), .R0_RDATA(rd0[k]),
            .R1_REQ(req1), .R1_WE(we1), .R1_ADDR(addr1), .R1_WDATA(wdata1),
            .R1_GNT(gnt1[k]), .R1_RVALID(rv1[k]), .R1_RDATA(rd1[k]),
            .SRAM_CE(ce[k]), .SRAM_WE(swe[k]), .SRAM_ADDR(saddr[k]), .SRAM_WDATA(swdata[k]),
            .SRAM_RDATA(srdata[k]), .BUSY(busy[k])
        );

        // Behavioural SRAM: data of a read sampled at an edge appears k+1 edges later
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < NW; i++) smem[i] <= init_word(i);
            end else if (ce[k] && swe[k]) begin
                smem[saddr[k]] <= swdata[k];
            end
            spipe[0] <= (ce[k] && !swe[k]) ? smem[saddr[k]] : 32'hDEAD_BEEF;
            for (int i = 1; i < NL; i++) spipe[i] <= spipe[i-1];
        end
        assign srdata[k] = spipe[k];
    end

    int checks;
    int failures;
    int cyc;
    int owner;
    int cnt;
    int last;
    logic e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] mmem [0:NW-1];
    logic sv [NL][8];
    logic sid [NL][8];
    logic [DW-1:0] sd [NL][8];
    logic p_req [2];
    logic p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd [2];
    op_t dq0 [$];
    op_t dq1 [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply_inputs();
        req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
        req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
    endtask

    task automatic model_reset();
        owner = -1; cnt = 0; last = 1;
        e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        for (int k = 0; k < NL; k++)
            for (int s = 0; s < 8; s++) begin
                sv[k][s] = 1'b0; sid[k][s] = 1'b0; sd[k][s] = '0;
            end
        for (int r = 0; r < 2; r++) begin
            p_req[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_wd[r] = '0;
        end
        dq0.delete();
        dq1.delete();
        apply_inputs();
    endtask

    // New requests only once the previous one was granted (requests are held until GNT)
    task automatic drive(input int p0, input int p1);
        op_t op;
        for (int r = 0; r < 2; r++) begin
            if (!p_req[r]) begin
                if (r == 0 && dq0.size() > 0) begin
                    op = dq0.pop_front();
                    p_req[0] = 1'b1; p_we[0] = op.we; p_addr[0] = op.addr; p_wd[0] = op.wd;
                end else if (r == 1 && dq1.size() > 0) begin
                    op = dq1.pop_front();
                    p_req[1] = 1'b1; p_we[1] = op.we; p_addr[1] = op.addr; p_wd[1] = op.wd;
                end else if ($urandom_range(99) < ((r == 0) ? p0 : p1)) begin
                    p_req[r]  = 1'b1;
                    p_we[r]   = 1'($urandom_range(1));
                    p_addr[r] = AW'($urandom_range(31));
                    p_wd[r]   = $urandom;
                end
            end
        end
        apply_inputs();
    endtask

    // Round-robin with burst cap, expressed on requester indices
    function automatic int pick();
        int oth;
        if (!p_req[0] && !p_req[1]) return -1;
        if (owner < 0) return (p_req[0] && p_req[1]) ? 1 - last : (p_req[0] ? 0 : 1);
        oth = 1 - owner;
        if (p_req[owner] && !(cnt == BMAX && p_req[oth])) return owner;
        if (p_req[oth]) return oth;
        return -1;
    endfunction

    task automatic check_all(input int g);
        int s;
        logic eb;
        s = cyc % 8;
        for (int k = 0; k < NL; k++) begin
            check_eq($sformatf("L%0d gnt0", k + 1), 64'(gnt0[k]), 64'(g == 0));
            check_eq($sformatf("L%0d gnt1", k + 1), 64'(gnt1[k]), 64'(g == 1));
            check_eq($sformatf("L%0d sram_ce", k + 1), 64'(ce[k]), 64'(e_ce));
            check_eq($sformatf("L%0d sram_we", k + 1), 64'(swe[k]), 64'(e_we));
            check_eq($sformatf("L%0d sram_addr", k + 1), 64'(saddr[k]), 64'(e_addr));
            check_eq($sformatf("L%0d sram_wdata", k + 1), 64'(swdata[k]), 64'(e_wd));
            check_eq($sformatf("L%0d rvalid0", k + 1), 64'(rv0[k]), 64'(sv[k][s] && !sid[k][s]));
            check_eq($sformatf("L%0d rvalid1", k + 1), 64'(rv1[k]), 64'(sv[k][s] && sid[k][s]));
            if (sv[k][s] && !sid[k][s]) check_eq($sformatf("L%0d rdata0", k + 1), 64'(rd0[k]), 64'(sd[k][s]));
            if (sv[k][s] && sid[k][s])  check_eq($sformatf("L%0d rdata1", k + 1), 64'(rd1[k]), 64'(sd[k][s]));
            eb = (owner >= 0);
            for (int j = 1; j <= k + 2; j++) eb = eb | sv[k][(cyc + j) % 8];
            check_eq($sformatf("L%0d busy", k + 1), 64'(busy[k]), 64'(eb));
            sv[k][s] = 1'b0;
        end
    endtask

    task automatic update(input int g);
        int s;
        if (g >= 0) begin
            e_ce = 1'b1; e_we = p_we[g]; e_addr = p_addr[g]; e_wd = p_wd[g];
            if (p_we[g]) begin
                mmem[p_addr[g]] = p_wd[g];
            end else begin
                for (int k = 0; k < NL; k++) begin
                    s = (cyc + 3 + k) % 8;
                    sv[k][s] = 1'b1; sid[k][s] = (g == 1); sd[k][s] = mmem[p_addr[g]];
                end
            end
            p_req[g] = 1'b0;
            if (g == owner) cnt = (cnt < BMAX) ? cnt + 1 : BMAX;
            else begin owner = g; cnt = 1; end
            last = g;
        end else begin
            e_ce = 1'b0; owner = -1; cnt = 0;
        end
        cyc++;
    endtask

    // One clock: entered and left 1 time unit after a rising edge
    task automatic run_cycle(input int p0, input int p1);
        int g;
        drive(p0, p1);
        g = pick();
        @(negedge clk);
        check_all(g);
        @(posedge clk);
        update(g);
        #1;
    endtask

    task automatic reset_check(input string tag);
        for (int k = 0; k < NL; k++) begin
            check_eq($sformatf("%s L%0d gnt", tag, k + 1), 64'({gnt0[k], gnt1[k]}), 64'd0);
            check_eq($sformatf("%s L%0d rvalid", tag, k + 1), 64'({rv0[k], rv1[k]}), 64'd0);
            check_eq($sformatf("%s L%0d sram_ctl", tag, k + 1), 64'({ce[k], swe[k], busy[k]}), 64'd0);
            check_eq($sformatf("%s L%0d sram_addr", tag, k + 1), 64'(saddr[k]), 64'd0);
            check_eq($sformatf("%s L%0d sram_wdata", tag, k + 1), 64'(swdata[k]), 64'd0);
            check_eq($sformatf("%s L%0d rdata", tag, k + 1), {rd0[k], rd1[k]}, 64'd0);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; mem_init = 1'b1;
        model_reset();
        for (int i = 0; i < NW; i++) mmem[i] = init_word(i);
        @(posedge clk); @(posedge clk); #1;
        reset_check("por");
        mem_init = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read the same word from R0
        dq0.push_back({1'b1, 10'h010, 32'hA5A5_0001});
        dq0.push_back({1'b0, 10'h010, 32'h0000_0000});
        for (int i = 0; i < 8; i++) run_cycle(0, 0);

        // Interleaved reads of preloaded words
        dq0.push_back({1'b0, 10'h001, 32'h0000_0000});
        dq1.push_back({1'b0, 10'h002, 32'h0000_0000});
        dq0.push_back({1'b0, 10'h003, 32'h0000_0000});
        for (int i = 0; i < 8; i++) run_cycle(0, 0);

        // Reset with two reads in flight and a third request still held
        dq0.push_back({1'b0, 10'h005, 32'h0000_0000});
        dq1.push_back({1'b0, 10'h006, 32'h0000_0000});
        dq0.push_back({1'b0, 10'h007, 32'h0000_0000});
        run_cycle(0, 0);
        run_cycle(0, 0);
        drive(0, 0);
        #1 rst = 1'b1;
        #1 reset_check("mid");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Both requesting continuously from reset: bursts of four, R0 first
        for (int i = 0; i < 20; i++) run_cycle(100, 100);
        for (int i = 0; i < 4; i++) run_cycle(0, 0);

        // R1 alone beyond the cap, then R0 joins
        for (int i = 0; i < 10; i++) run_cycle(0, 100);
        for (int i = 0; i < 10; i++) run_cycle(100, 100);
        for (int i = 0; i < 4; i++) run_cycle(0, 0);

        // Random traffic with varying request rates
        for (int ph = 0; ph < 15; ph++) begin
            int a, b;
            a = $urandom_range(100);
            b = $urandom_range(100);
            for (int i = 0; i < 20; i++) run_cycle(a, b);
        end
        for (int i = 0; i < 8; i++) run_cycle(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
